// File: rtl/operand2_pkg.sv
// ---------------------------------------------------------------------------
// operand2_pkg
// Shared types and helpers for the operand2 immediate encoder.
//   state_e : encoder FSM states (IDLE, SEARCH, DONE)
//   cand_e  : which form of the constant is being encoded
//             (direct value, bitwise inverse, two's-complement negation)
//   ROT_MAX : highest 4-bit rotation field value
//   IMM8_W  : width of the immediate byte
//   rol32   : 32-bit rotate-left by a 5-bit amount
// ---------------------------------------------------------------------------
package operand2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAND_DIRECT = 2'd0,
    CAND_INV    = 2'd1,
    CAND_NEG    = 2'd2
  } cand_e;

  localparam logic [3:0] ROT_MAX = 4'd15;
  localparam int         IMM8_W  = 8;

  // Rotating the doubled word left and keeping the upper half gives a
  // rotate without any shift-by-32 corner case when amount is 0.
  function automatic logic [31:0] rol32(input logic [31:0] word,
                                        input logic [4:0]  amount);
    logic [63:0] dbl;
    dbl = {word, word} << amount;
    return dbl[63:32];
  endfunction

endpackage

// File: rtl/imm_rot_check.sv
// ---------------------------------------------------------------------------
// imm_rot_check
// Combinational test of one rotation lane: does word_i equal some imm8
// rotated right by 2*(base_rot_i + LANE)?
//   word_i     : candidate word under test
//   base_rot_i : rotation of lane 0 in the current group
//   hit_o      : the word is encodable at this lane's rotation
//   hit_rot_o  : this lane's rotation (base_rot_i + LANE)
//   imm8_o     : immediate byte that reproduces the word at hit_rot_o
// ---------------------------------------------------------------------------
module imm_rot_check
  import operand2_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic [31:0]       word_i,
  input  logic [3:0]        base_rot_i,
  output logic              hit_o,
  output logic [3:0]        hit_rot_o,
  output logic [IMM8_W-1:0] imm8_o
);

  logic [31:0] rotated;

  // Undoing the decoder's rotate-right means rotating left by the same
  // amount; the word is encodable when everything above the byte is zero.
  always_comb begin
    hit_rot_o = base_rot_i + 4'(LANE);
    rotated   = rol32(word_i, {hit_rot_o, 1'b0});
    hit_o     = (rotated[31:IMM8_W] == '0);
    imm8_o    = rotated[IMM8_W-1:0];
  end

endmodule

// File: rtl/operand2_imm_encoder.sv
// ---------------------------------------------------------------------------
// operand2_imm_encoder
// Iteratively searches for a {rot4, imm8} operand2 encoding of a 32-bit
// constant, optionally falling back to its inverse or its negation.
//   clk, reset          : rising-edge clock, async active-high reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_value           : constant to encode
//   req_alt_en          : bit0 enables inverted, bit1 enables negated
//   res_valid/res_ready : result handshake (valid only in DONE)
//   res_found           : an encoding was found
//   res_cand            : 0 direct, 1 inverted, 2 negated
//   res_src2            : {rot4, imm8}
//   res_carry_upd       : rotation is nonzero, shifter carry comes from bit31
//   res_carry           : bit31 of the encoded candidate
// ---------------------------------------------------------------------------
module operand2_imm_encoder
  import operand2_pkg::*;
#(
  parameter int ROTS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_value,
  input  logic [1:0]  req_alt_en,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_found,
  output logic [1:0]  res_cand,
  output logic [11:0] res_src2,
  output logic        res_carry_upd,
  output logic        res_carry
);

  localparam logic [3:0] RPC_STEP = 4'(ROTS_PER_CYCLE);
  localparam logic [3:0] RPC_M1   = 4'(ROTS_PER_CYCLE - 1);

  state_e      state_q;
  logic [31:0] value_q;
  logic [1:0]  alt_q;
  cand_e       cand_q;
  logic [3:0]  rot_q;

  logic        found_q;
  cand_e       res_cand_q;
  logic [11:0] src2_q;
  logic        carry_upd_q;
  logic        carry_q;

  logic [31:0]       word;
  logic              lane_hit [ROTS_PER_CYCLE];
  logic [3:0]        lane_rot [ROTS_PER_CYCLE];
  logic [IMM8_W-1:0] lane_imm [ROTS_PER_CYCLE];

  logic              grp_hit_d;
  logic [3:0]        grp_rot_d;
  logic [IMM8_W-1:0] grp_imm_d;
  logic              grp_last;
  logic              next_valid_d;
  cand_e             next_cand_d;

  // Form the word currently under test from the latched constant.
  always_comb begin
    case (cand_q)
      CAND_INV: word = ~value_q;
      CAND_NEG: word = 32'd0 - value_q;
      default:  word = value_q;
    endcase
  end

  for (genvar k = 0; k < ROTS_PER_CYCLE; k++) begin : g_lane
    imm_rot_check #(.LANE(k)) u_check (
      .word_i     (word),
      .base_rot_i (rot_q),
      .hit_o      (lane_hit[k]),
      .hit_rot_o  (lane_rot[k]),
      .imm8_o     (lane_imm[k])
    );
  end

  // Scan lanes from highest to lowest so the lowest hitting rotation is
  // the one left standing.
  always_comb begin
    grp_hit_d = 1'b0;
    grp_rot_d = '0;
    grp_imm_d = '0;
    for (int k = ROTS_PER_CYCLE - 1; k >= 0; k--) begin
      if (lane_hit[k]) begin
        grp_hit_d = 1'b1;
        grp_rot_d = lane_rot[k];
        grp_imm_d = lane_imm[k];
      end
    end
    grp_last = ((rot_q + RPC_M1) == ROT_MAX);
  end

  // Pick the next enabled fallback candidate in priority order, skipping
  // any that the request did not enable.
  always_comb begin
    next_valid_d = 1'b0;
    next_cand_d  = CAND_DIRECT;
    case (cand_q)
      CAND_DIRECT: begin
        if (alt_q[0]) begin
          next_valid_d = 1'b1;
          next_cand_d  = CAND_INV;
        end else if (alt_q[1]) begin
          next_valid_d = 1'b1;
          next_cand_d  = CAND_NEG;
        end
      end
      CAND_INV: begin
        if (alt_q[1]) begin
          next_valid_d = 1'b1;
          next_cand_d  = CAND_NEG;
        end
      end
      default: ;
    endcase
  end

  // Main FSM: accept in IDLE, test one rotation group per SEARCH cycle,
  // hold the registered result in DONE until consumed. Result registers
  // are cleared on accept so a failed search reports all zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      value_q     <= '0;
      alt_q       <= '0;
      cand_q      <= CAND_DIRECT;
      rot_q       <= '0;
      found_q     <= 1'b0;
      res_cand_q  <= CAND_DIRECT;
      src2_q      <= '0;
      carry_upd_q <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            value_q     <= req_value;
            alt_q       <= req_alt_en;
            cand_q      <= CAND_DIRECT;
            rot_q       <= '0;
            found_q     <= 1'b0;
            res_cand_q  <= CAND_DIRECT;
            src2_q      <= '0;
            carry_upd_q <= 1'b0;
            carry_q     <= 1'b0;
            state_q     <= SEARCH;
          end
        end
        SEARCH: begin
          if (grp_hit_d) begin
            found_q     <= 1'b1;
            res_cand_q  <= cand_q;
            src2_q      <= {grp_rot_d, grp_imm_d};
            carry_upd_q <= (grp_rot_d != 4'd0);
            carry_q     <= word[31];
            state_q     <= DONE;
          end else if (!grp_last) begin
            rot_q <= rot_q + RPC_STEP;
          end else if (next_valid_d) begin
            cand_q <= next_cand_d;
            rot_q  <= '0;
          end else begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (res_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign res_valid     = (state_q == DONE);
  assign res_found     = found_q;
  assign res_cand      = res_cand_q;
  assign res_src2      = src2_q;
  assign res_carry_upd = carry_upd_q;
  assign res_carry     = carry_q;

endmodule

// File: tb/tb_operand2_imm_encoder.sv
// ---------------------------------------------------------------------------
// tb_operand2_imm_encoder
// Self-checking bench for operand2_imm_encoder (ROTS_PER_CYCLE = 1):
// directed vector table, randomized requests against a decode-based
// reference model, backpressure hold and reset mid-search.
// ---------------------------------------------------------------------------
module tb_operand2_imm_encoder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_value;
  logic [1:0]  req_alt_en;
  logic        res_valid;
  logic        res_ready;
  logic        res_found;
  logic [1:0]  res_cand;
  logic [11:0] res_src2;
  logic        res_carry_upd;
  logic        res_carry;

  int checks = 0;
  int errors = 0;

  operand2_imm_encoder #(.ROTS_PER_CYCLE(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_value     (req_value),
    .req_alt_en    (req_alt_en),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_found     (res_found),
    .res_cand      (res_cand),
    .res_src2      (res_src2),
    .res_carry_upd (res_carry_upd),
    .res_carry     (res_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] value;
    logic [1:0]  alt;
    bit          found;
    int          cand;
    logic [11:0] src2;
    bit          cupd;
    bit          carry;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  // Rotate right, as the datapath decoder does.
  function automatic logic [31:0] ror32m(input logic [31:0] w, input int amt);
    logic [63:0] d;
    d = {w, w} >> amt;
    return d[31:0];
  endfunction

  // Reference: walk enabled candidates in priority order and, for every
  // rotation, brute-force the immediate byte whose decode equals the word.
  function automatic vec_t refModel(input logic [31:0] v, input logic [1:0] alt);
    vec_t r;
    int tests;
    bit done;
    logic [31:0] w;
    logic [7:0] imm8;
    logic [3:0] rot4;
    r.value = v; r.alt = alt; r.found = 0; r.cand = 0; r.src2 = 0;
    r.cupd = 0; r.carry = 0;
    tests = 0;
    done = 0;
    for (int c = 0; c < 3; c++) begin
      if (done) break;
      if (c == 1 && !alt[0]) continue;
      if (c == 2 && !alt[1]) continue;
      w = (c == 0) ? v : (c == 1) ? ~v : (32'd0 - v);
      for (int rot = 0; rot < 16; rot++) begin
        if (done) break;
        tests++;
        for (int imm = 0; imm < 256; imm++) begin
          if (ror32m(32'(imm), 2 * rot) == w) begin
            imm8 = 8'(imm);
            rot4 = 4'(rot);
            r.found = 1;
            r.cand  = c;
            r.src2  = {rot4, imm8};
            r.cupd  = (rot != 0);
            r.carry = w[31];
            done = 1;
            break;
          end
        end
      end
    end
    r.lat = tests + 1;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request and count edges from the accept edge until res_valid
  // is seen. Inputs are scrambled after acceptance; they must be ignored.
  task automatic applyStimulus(input logic [31:0] v, input logic [1:0] a,
                               output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_value  = v;
    req_alt_en = a;
    @(posedge clk);
    lat = 1;
    #1;
    req_valid  = 1'b0;
    req_value  = $urandom;
    req_alt_en = 2'($urandom_range(0, 3));
    while (!res_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
    end
    checkOutput("res_valid_timeout", 32'(res_valid), 32'd1);
  endtask

  task automatic consumeResult();
    @(negedge clk);
    checkOutput("req_ready_in_done", 32'(req_ready), 32'd0);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    checkOutput("res_valid_after_consume", 32'(res_valid), 32'd0);
    checkOutput("req_ready_after_consume", 32'(req_ready), 32'd1);
  endtask

  task automatic checkResult(input string tag, input vec_t e, input int lat);
    checkOutput({tag, "_found"}, 32'(res_found), 32'(e.found));
    checkOutput({tag, "_cand"}, 32'(res_cand), 32'(e.cand));
    checkOutput({tag, "_src2"}, 32'(res_src2), 32'(e.src2));
    checkOutput({tag, "_carry_upd"}, 32'(res_carry_upd), 32'(e.cupd));
    checkOutput({tag, "_carry"}, 32'(res_carry), 32'(e.carry));
    checkOutput({tag, "_latency"}, 32'(lat), 32'(e.lat));
  endtask

  initial begin
    int lat;
    vec_t e;
    logic [11:0] s2;
    logic [31:0] wexp;
    logic [31:0] v;
    int mode;

    vecs[0]  = '{32'h000000FF, 2'b00, 1, 0, 12'h0FF, 0, 0, 2};
    vecs[1]  = '{32'hFF000000, 2'b00, 1, 0, 12'h4FF, 1, 1, 6};
    vecs[2]  = '{32'hF000000F, 2'b00, 1, 0, 12'h2FF, 1, 1, 4};
    vecs[3]  = '{32'hFFFFFF00, 2'b01, 1, 1, 12'h0FF, 0, 0, 18};
    vecs[4]  = '{32'hFFFFFF01, 2'b10, 1, 2, 12'h0FF, 0, 0, 18};
    vecs[5]  = '{32'hFFFFFF01, 2'b00, 0, 0, 12'h000, 0, 0, 17};
    vecs[6]  = '{32'h00000102, 2'b11, 0, 0, 12'h000, 0, 0, 49};
    vecs[7]  = '{32'h00000000, 2'b00, 1, 0, 12'h000, 0, 0, 2};
    vecs[8]  = '{32'h80000000, 2'b10, 1, 0, 12'h102, 1, 1, 3};
    vecs[9]  = '{32'hFFFFFFFF, 2'b11, 1, 1, 12'h000, 0, 0, 18};
    vecs[10] = '{32'h000003FC, 2'b00, 1, 0, 12'hFFF, 1, 0, 17};

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_value  = '0;
    req_alt_en = '0;
    res_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_res_valid", 32'(res_valid), 32'd0);
    checkOutput("reset_res_found", 32'(res_found), 32'd0);
    checkOutput("reset_res_cand", 32'(res_cand), 32'd0);
    checkOutput("reset_res_src2", 32'(res_src2), 32'd0);
    checkOutput("reset_res_carry_upd", 32'(res_carry_upd), 32'd0);
    checkOutput("reset_res_carry", 32'(res_carry), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table, plus rebuilding the constant from src2 the way the
    // shifter's immediate path would.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].value, vecs[i].alt, lat);
      checkResult($sformatf("vec%0d", i), vecs[i], lat);
      if (vecs[i].found) begin
        s2 = res_src2;
        wexp = (vecs[i].cand == 0) ? vecs[i].value :
               (vecs[i].cand == 1) ? ~vecs[i].value : (32'd0 - vecs[i].value);
        checkOutput($sformatf("vec%0d_decode", i),
                    ror32m(32'(s2[7:0]), 2 * int'(s2[11:8])), wexp);
      end
      consumeResult();
    end

    // Randomized requests, biased towards encodable words and their
    // inverse/negation so all three candidates get exercised.
    for (int i = 0; i < 40; i++) begin
      v = ror32m(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)));
      mode = int'($urandom_range(0, 3));
      if (mode == 1) v = ~v;
      else if (mode == 2) v = 32'd0 - v;
      else if (mode == 3) v = $urandom;
      e = refModel(v, 2'($urandom_range(0, 3)));
      applyStimulus(e.value, e.alt, lat);
      checkResult($sformatf("rnd%0d", i), e, lat);
      consumeResult();
    end

    // Backpressure: result must hold while res_ready stays low, and a
    // competing request must not be accepted.
    applyStimulus(32'hFF000000, 2'b00, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_value = 32'h000000FF;
      checkOutput("hold_res_valid", 32'(res_valid), 32'd1);
      checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
      checkOutput("hold_src2", 32'(res_src2), 32'h4FF);
      checkOutput("hold_cand", 32'(res_cand), 32'd0);
      checkOutput("hold_carry", 32'(res_carry), 32'd1);
    end
    req_valid = 1'b0;
    consumeResult();

    // Reset in the middle of a long search aborts with no result.
    applyStimulus(32'h00000102, 2'b11, lat);
    consumeResult();
    @(negedge clk);
    req_valid  = 1'b1;
    req_value  = 32'h00000102;
    req_alt_en = 2'b11;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("pre_abort_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("abort_res_valid", 32'(res_valid), 32'd0);
    checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
    checkOutput("abort_res_found", 32'(res_found), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // The block must work normally after the abort.
    applyStimulus(32'h000000FF, 2'b00, lat);
    checkResult("post_abort", vecs[0], lat);
    consumeResult();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
